// File: rtl/sc_phase_sequencer_if.sv
// Control/status bundle between a run initiator (master) and the phase sequencer (slave).
interface sc_phase_sequencer_if #(
  parameter int unsigned N_R = 81,
  parameter int unsigned FXP = 8,
  parameter int unsigned LW  = 16
);
  localparam int unsigned D  = N_R * FXP;
  localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;

  logic          start;
  logic          abort;
  logic [LW-1:0] stream_len;
  logic          two_phase_en;
  logic          readout_en;

  logic          compute_en;
  logic          comp_positive_phase;
  logic          read_en;
  logic [AW-1:0] READ_ADDR;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, stream_len, two_phase_en, readout_en,
    input  compute_en, comp_positive_phase, read_en, READ_ADDR, busy, done
  );

  modport slave (
    input  start, abort, stream_len, two_phase_en, readout_en,
    output compute_en, comp_positive_phase, read_en, READ_ADDR, busy, done
  );
endinterface

// File: rtl/sc_phase_sequencer.sv
// Sequences a stochastic-compute run: positive phase, optional negative phase,
// optional weight readout sweep, then a one-cycle done.
module sc_phase_sequencer #(
  parameter int unsigned N_R = 81,
  parameter int unsigned FXP = 8,
  parameter int unsigned LW  = 16
) (
  input logic                 CLK,
  input logic                 RESET,
  sc_phase_sequencer_if.slave bus
);
  localparam int unsigned D  = N_R * FXP;
  localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(D - 1);

  typedef enum logic [2:0] {StIdle, StPos, StNeg, StRead, StDone} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          two_q, two_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;

  // State, counters and latched configuration.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      two_q   <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      two_q   <= two_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and counter logic; cnt_q holds the remaining cycles of the current phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    two_d   = two_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            len_d = bus.stream_len;
            two_d = bus.two_phase_en;
            rd_d  = bus.readout_en;
            if (bus.stream_len != '0) begin
              state_d = StPos;
              cnt_d   = bus.stream_len;
            end else if (bus.readout_en) begin
              state_d = StRead;
            end else begin
              state_d = StDone;
            end
          end
        end
        StPos: begin
          if (cnt_q == LW'(1)) begin
            if (two_q) begin
              state_d = StNeg;
              cnt_d   = len_q;
            end else begin
              state_d = rd_q ? StRead : StDone;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        StNeg: begin
          if (cnt_q == LW'(1)) begin
            state_d = rd_q ? StRead : StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        StRead: begin
          if (addr_q == LastAddr) begin
            state_d = StDone;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        StDone: state_d = StIdle;
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          addr_d  = '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state and address only.
  always_comb begin
    bus.compute_en          = (state_q == StPos) || (state_q == StNeg);
    bus.comp_positive_phase = (state_q == StPos);
    bus.read_en             = (state_q == StRead);
    bus.READ_ADDR           = addr_q;
    bus.busy                = (state_q != StIdle);
    bus.done                = (state_q == StDone);
  end
endmodule

// File: doc/sc_phase_sequencer.md
SC_PHASE_SEQUENCER -- requirements
Module: sc_phase_sequencer

Interface
REQ-001 Parameter N_R, default 81: number of array rows.
REQ-002 Parameter FXP, default 8: fixed-point bits per row; readout depth D = N_R*FXP (648 by default).
REQ-003 Parameter LW, default 16: width of the stream-length field.
REQ-004 Port CLK, input, 1: single clock; all logic on the rising edge.
REQ-005 Port RESET, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle request to begin a run; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminates any run.
REQ-008 Port stream_len, input, LW: compute cycles per phase; captured at start.
REQ-009 Port two_phase_en, input, 1: when set, a negative phase follows the positive phase; captured at start.
REQ-010 Port readout_en, input, 1: when set, a weight-LFSR readout sweep follows compute; captured at start.
REQ-011 Port compute_en, output, 1: enables SNG/LFSR stepping downstream.
REQ-012 Port comp_positive_phase, output, 1: 1 during the positive phase, 0 otherwise.
REQ-013 Port read_en, output, 1: readout sweep active.
REQ-014 Port READ_ADDR, output, $clog2(N_R*FXP): readout address.
REQ-015 Port busy, output, 1: high in any state other than IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when a run completes normally.

Function
REQ-017 FSM states: IDLE, POS, NEG, READ, DONE. All outputs are registered and decoded from the state and counters.
REQ-018 IDLE + start: latch stream_len, two_phase_en and readout_en.
  - latched stream_len > 0: go to POS.
  - latched stream_len = 0 with readout_en: go to READ.
  - otherwise: go to DONE.
REQ-019 First-cycle latency: start sampled at edge t gives compute_en (or read_en) = 1 in the cycle after edge t.
REQ-020 POS: compute_en=1, comp_positive_phase=1 for exactly the latched stream_len cycles. A down-counter is loaded at entry and decremented each cycle.
REQ-021 POS exit, on the last cycle: go to NEG if two_phase_en; else to READ if readout_en; else to DONE.
REQ-022 NEG: compute_en=1, comp_positive_phase=0 for exactly stream_len cycles. Exit goes to READ if readout_en, else to DONE.
REQ-023 POS→NEG is gap-free: compute_en stays 1 across the boundary and comp_positive_phase falls on the first NEG cycle.
REQ-024 READ: read_en=1, compute_en=0, READ_ADDR = 0,1,…,D-1, one address per cycle, D cycles total. Exit goes to DONE.
REQ-025 After the sweep, READ_ADDR returns to 0. It never exceeds D-1, with no wrap within a sweep.
REQ-026 compute_en and read_en are never both 1 in the same cycle.
REQ-027 DONE lasts one cycle: done=1, busy=1, all enables 0. The next state is IDLE.
REQ-028 start outside IDLE is ignored, including in DONE, and has no effect on latched configuration.
REQ-029 abort in any non-IDLE state: the next cycle is IDLE, with all enables 0, READ_ADDR=0, done not asserted, and counters cleared.
REQ-030 abort and start asserted together in IDLE: abort wins and the FSM stays in IDLE.
REQ-031 Changes to stream_len, two_phase_en or readout_en during a run do not affect that run.
REQ-032 Maximum stream_len = 2^LW-1. The counter must not overflow or wrap.

Reset
REQ-033 RESET=1 at an edge forces IDLE at the next cycle from any state, including mid-phase and mid-sweep.
REQ-034 Reset values: compute_en=0, comp_positive_phase=0, read_en=0, READ_ADDR=0, busy=0, done=0, and all counters and latched configuration 0.
REQ-035 RESET takes priority over abort and start.

Verification
REQ-036 Positive-phase-only run: stream_len=4, two_phase_en=0, readout_en=0, start pulse.
  - Expect compute_en=1 and comp_positive_phase=1 for 4 cycles starting the cycle after start.
  - Then one done pulse, with busy high for 5 cycles total.
REQ-037 Full run: stream_len=3, two_phase_en=1, readout_en=1.
  - Expect 3 cycles with phase=1 and 3 with phase=0, compute_en continuous for 6 cycles.
  - Then read_en for 648 cycles with READ_ADDR 0→647, then done.
  - compute_en and read_en never overlap.
REQ-038 Zero-length run: stream_len=0, readout_en=1: READ immediately, no compute_en cycle. With readout_en=0: done the cycle after start.
REQ-039 Abort mid-sweep: abort at READ_ADDR=100. Next cycle is IDLE, read_en=0, READ_ADDR=0, and no done. A following start runs normally.
REQ-040 Reset mid-NEG: RESET=1 during NEG gives all outputs at reset values next cycle. start asserted while busy, and start held with abort, are both ignored.
